uart_rx_fifo: RTL and testbench

//  UART receive front-end feeding the SoC's serial input path. Samples rs232_dce_rxd at 16x oversampling and

---
 rtl/uart_rx_fifo_pkg.sv | 21 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and FSM state encoding for the UART receive front-end.
// Optional parity support is enabled with the UART_RX_PARITY_EN macro.
package uart_rx_fifo_pkg;

  localparam int unsigned OVS = 16;
  localparam int unsigned MID = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Rounded clk / (16 * baud) divider.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO; occupancy kept in its own register.
// Head reads as zero while empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push at full is accepted only when a pop frees the head slot in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART deframer feeding a FWFT byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit checked against PARITY_ODD.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err,
  input  logic                          err_clr
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      phase_q, phase_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            bad_q, bad_d;
  logic            push_q, push_d;
  logic            frame_err_q, parity_err_q, overrun_q;
  logic            set_ferr, set_perr, set_ovr;
  logic            tick, fall, fifo_full, fifo_empty, pop;

  assign tick = (tick_cnt_q == TW'(DIV - 1));
  assign fall = prev_q && !sync2_q;
  assign pop  = rx_ready && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    bad_d      = bad_q;
    push_d     = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    unique case (state_q)
      ST_IDLE: begin
        // Restart the tick divider on the edge so every sample lands at a fixed mid-bit offset.
        if (fall) begin
          state_d    = ST_START;
          phase_d    = '0;
          tick_cnt_d = '0;
          bad_d      = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (phase_q == 4'(MID)) begin
            state_d   = sync2_q ? ST_IDLE : ST_DATA;
            phase_d   = '0;
            bit_cnt_d = '0;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (phase_q == 4'(OVS - 1)) begin
            phase_d   = '0;
            shift_d   = {sync2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (phase_q == 4'(OVS - 1)) begin
            phase_d = '0;
            state_d = ST_STOP;
            if ((^{shift_q, sync2_q}) != PARITY_ODD) begin
              set_perr = 1'b1;
              bad_d    = 1'b1;
            end
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (phase_q == 4'(OVS - 1)) begin
            phase_d = '0;
            state_d = ST_IDLE;
            if (!sync2_q)    set_ferr = 1'b1;
            else if (!bad_q) push_d   = 1'b1;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign set_ovr = push_q && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      bad_q        <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      bad_q      <= bad_d;
      push_q     <= push_d;
      // A same-cycle set outranks err_clr.
      if (set_ferr)     frame_err_q  <= 1'b1;
      else if (err_clr) frame_err_q  <= 1'b0;
      if (set_perr)     parity_err_q <= 1'b1;
      else if (err_clr) parity_err_q <= 1'b0;
      if (set_ovr)      overrun_q    <= 1'b1;
      else if (err_clr) overrun_q    <= 1'b0;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (rx_ready),
    .data_o  (rx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid   = !fifo_empty;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand sequences for overflow, glitch and reset.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ   = 7_372_800;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset, rxd, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       overrun, frame_err, parity_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .err_clr    (err_clr)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Caller is at a negedge; returns at a negedge with the line idle.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`endif
    send_bit(stop_b);
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_data"},  32'(rx_data),  32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_ovr"},   32'(overrun),  32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_perr"},  32'(parity_err), 32'd0);
  endtask

  int unsigned k_valid;

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_push: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h80, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'hC6, stop: 1'b0, exp_push: 1'b0, exp_ferr: 1'b1};

    reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 0x55: byte appears roughly 9.5 bit times plus synchroniser delay after the start edge.
    k_valid = 0;
    fork
      send_frame(8'h55, 1'b1, ^8'h55);
      begin
        for (int unsigned i = 1; i <= 700; i++) begin
          @(negedge clk);
          if (rx_valid && k_valid == 0) k_valid = i;
        end
      end
    join
    check("t1_latency_window", 32'(k_valid >= 600 && k_valid <= 625), 32'd1);
    check("t1_data",  32'(rx_data), 32'h55);
    check("t1_count", 32'(fifo_count), 32'd1);
    check("t1_flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    check("t1_drained", 32'(fifo_count), 32'd0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, ^vecs[v].data);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_count", v), 32'(fifo_count), 32'(vecs[v].exp_push));
      check($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'(vecs[v].exp_push));
      check($sformatf("vec%0d_data", v), 32'(rx_data), 32'(vecs[v].exp_push ? vecs[v].data : 8'h00));
      check($sformatf("vec%0d_ferr", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_perr", v), 32'(parity_err), 32'd0);
      rx_ready = 1'b1;
      pulse_clr();
      rx_ready = 1'b0;
      check($sformatf("vec%0d_clr", v), {30'd0, frame_err, rx_valid}, 32'd0);
    end

    // Overflow: 17 frames into a 16-deep FIFO with no reader.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, ^8'(i));
    repeat (4) @(negedge clk);
    check("ovf_count", 32'(fifo_count), 32'd16);
    check("ovf_flag",  32'(overrun), 32'd1);
    check("ovf_head",  32'(rx_data), 32'h00);
    pulse_clr();
    check("ovf_clr", 32'(overrun), 32'd0);

    // Push coinciding with a pop at full: both take effect, no overrun.
    fork
      send_frame(8'h20, 1'b1, ^8'h20);
      begin
        repeat (k_valid - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("full_pp_count", 32'(fifo_count), 32'd16);
    check("full_pp_ovr",   32'(overrun), 32'd0);
    rx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain%0d", i), 32'(rx_data), (i == 16) ? 32'h20 : 32'(i));
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    check("drain_empty_valid", 32'(rx_valid), 32'd0);
    check("drain_empty_count", 32'(fifo_count), 32'd0);

    // Short low pulse (4 ticks) must be rejected as a glitch.
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_flags", {30'd0, frame_err, overrun}, 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    repeat (4) @(negedge clk);
    check("glitch_next_data",  32'(rx_data), 32'h3C);
    check("glitch_next_count", 32'(fifo_count), 32'd1);

    // Leave a byte and a sticky flag set, then reset mid-way through data bit 4 of 0x81.
    send_frame(8'h11, 1'b0, ^8'h11);
    repeat (4) @(negedge clk);
    check("pre_rst_ferr", 32'(frame_err), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0);
    rxd = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midrst");
    repeat (100) @(negedge clk);
    check("midrst_no_push", 32'(fifo_count), 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    repeat (4) @(negedge clk);
    check("midrst_next_data",  32'(rx_data), 32'h3C);
    check("midrst_next_count", 32'(fifo_count), 32'd1);
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("par_bad_perr",  32'(parity_err), 32'd1);
    check("par_bad_count", 32'(fifo_count), 32'd0);
    pulse_clr();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("par_ok_perr", 32'(parity_err), 32'd0);
    check("par_ok_data", 32'(rx_data), 32'h07);
    check("par_ok_count", 32'(fifo_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
